ptos_lane_sched: RTL

- Controller/scheduler for the parallel-to-serial IDLE datapath. Runs in the clk32f (bit) domain and owns slot timing: one byte slot per 8 clocks.
- Brings the lane up with a COM training burst, then sends upstream data bytes or IDLE fill, one symbol per slot.
- Drives the symbol and load strobe consumed by the serializer shift register, and drives the lane `active` flag.

---
 rtl/ptos_pkg.sv | 21 ++
 rtl/ptos_slot_timer.sv | 30 +++
 rtl/ptos_lane_sched.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ptos_pkg.sv
// Shared definitions for the parallel-to-serial lane scheduler:
// state encoding, default control symbols and slot timer width.
package ptos_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_TRAIN  = 2'd1,
        ST_ACTIVE = 2'd2
    } ptos_state_t;

    localparam int BIT_CNT_W = 3;

    // Last bit position of a byte slot; the edge seen at this count closes the slot.
    localparam logic [BIT_CNT_W-1:0] SLOT_LAST = 3'd7;

    localparam logic [7:0] COM_SYM_DEF   = 8'hBC;
    localparam logic [7:0] IDLE_SYM_DEF  = 8'h7C;
    localparam int         TRAIN_SYMS_DEF    = 4;
    localparam int         SKIP_INTERVAL_DEF = 16;

endpackage

// File: rtl/ptos_slot_timer.sv
// Bit position counter inside a byte slot. Runs while enabled, and is forced
// to zero by clr. boundary marks the clock edge that closes the current slot.
module ptos_slot_timer
    import ptos_pkg::*;
(
    input  logic                 clk32f,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 clr,
    output logic [BIT_CNT_W-1:0] bit_cnt,
    output logic                 boundary
);

    logic [BIT_CNT_W-1:0] bit_cnt_reg;

    // Count bit times within the slot, wrapping naturally at the slot length.
    always_ff @(posedge clk32f or posedge reset) begin
        if (reset) begin
            bit_cnt_reg <= '0;
        end else if (clr) begin
            bit_cnt_reg <= '0;
        end else if (en) begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
    end

    assign bit_cnt  = bit_cnt_reg;
    assign boundary = en && (bit_cnt_reg == SLOT_LAST);

endmodule

// File: rtl/ptos_lane_sched.sv
// Lane scheduler for the parallel-to-serial datapath. Brings the lane up with
// a COM training burst, then emits one data byte or IDLE fill per 8-clock slot.
// Optional periodic COM insertion in ACTIVE is compiled in with PTOS_SKIP_EN.
module ptos_lane_sched
    import ptos_pkg::*;
#(
    parameter int         TRAIN_SYMS = TRAIN_SYMS_DEF,
    parameter logic [7:0] COM_SYM    = COM_SYM_DEF,
    parameter logic [7:0] IDLE_SYM   = IDLE_SYM_DEF
`ifdef PTOS_SKIP_EN
    ,
    parameter int         SKIP_INTERVAL = SKIP_INTERVAL_DEF
`endif
)
(
    input  logic       clk32f,
    input  logic       reset,
    input  logic       link_en,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic [7:0] sym_out,
    output logic       sym_load,
    output logic       sym_is_k,
    output logic       active,
    output logic [1:0] state_o
);

    ptos_state_t          state_reg;
    logic [7:0]           train_cnt_reg;
    logic [7:0]           sym_out_reg;
    logic                 sym_load_reg;
    logic                 sym_is_k_reg;
    logic                 active_reg;

    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 boundary;
    logic                 timer_en;
    logic                 timer_clr;
    logic                 skip_due;

    // The slot clock only runs once the lane is being brought up; a link drop
    // at a boundary restarts it from zero for the next bring-up.
    assign timer_en  = (state_reg != ST_OFF);
    assign timer_clr = (state_reg == ST_OFF) || (boundary && !link_en);

    ptos_slot_timer u_slot_timer (
        .clk32f   (clk32f),
        .reset    (reset),
        .en       (timer_en),
        .clr      (timer_clr),
        .bit_cnt  (bit_cnt),
        .boundary (boundary)
    );

`ifdef PTOS_SKIP_EN
    logic [7:0] slot_cnt_reg;

    // Counts ACTIVE slots since entry; held at zero outside ACTIVE so that
    // each ACTIVE entry starts a fresh interval.
    always_ff @(posedge clk32f or posedge reset) begin
        if (reset) begin
            slot_cnt_reg <= '0;
        end else if (state_reg != ST_ACTIVE) begin
            slot_cnt_reg <= '0;
        end else if (boundary && link_en) begin
            slot_cnt_reg <= skip_due ? 8'd0 : slot_cnt_reg + 8'd1;
        end
    end

    assign skip_due = (state_reg == ST_ACTIVE) &&
                      (slot_cnt_reg == 8'(SKIP_INTERVAL - 1));
`else
    assign skip_due = 1'b0;
`endif

    // A byte is taken only on an ACTIVE boundary that actually emits data:
    // not during a pending link drop and not in a forced COM slot.
    assign data_ready = (state_reg == ST_ACTIVE) && (bit_cnt == SLOT_LAST) &&
                        link_en && !skip_due;

    // Lane FSM plus symbol mux; all serializer-facing outputs are registered.
    always_ff @(posedge clk32f or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_OFF;
            train_cnt_reg <= '0;
            sym_out_reg   <= '0;
            sym_load_reg  <= 1'b0;
            sym_is_k_reg  <= 1'b0;
            active_reg    <= 1'b0;
        end else begin
            sym_load_reg <= 1'b0;
            case (state_reg)
                ST_OFF: begin
                    active_reg <= 1'b0;
                    if (link_en) begin
                        state_reg     <= ST_TRAIN;
                        train_cnt_reg <= '0;
                    end
                end
                ST_TRAIN: begin
                    if (boundary) begin
                        if (!link_en) begin
                            state_reg  <= ST_OFF;
                            active_reg <= 1'b0;
                        end else begin
                            sym_out_reg   <= COM_SYM;
                            sym_is_k_reg  <= 1'b1;
                            sym_load_reg  <= 1'b1;
                            train_cnt_reg <= train_cnt_reg + 8'd1;
                            if (train_cnt_reg == 8'(TRAIN_SYMS - 1)) begin
                                state_reg  <= ST_ACTIVE;
                                active_reg <= 1'b1;
                            end
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (boundary) begin
                        if (!link_en) begin
                            state_reg  <= ST_OFF;
                            active_reg <= 1'b0;
                        end else begin
                            sym_load_reg <= 1'b1;
                            if (skip_due) begin
                                sym_out_reg  <= COM_SYM;
                                sym_is_k_reg <= 1'b1;
                            end else if (data_valid) begin
                                sym_out_reg  <= data_in;
                                sym_is_k_reg <= 1'b0;
                            end else begin
                                sym_out_reg  <= IDLE_SYM;
                                sym_is_k_reg <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_reg  <= ST_OFF;
                    active_reg <= 1'b0;
                end
            endcase
        end
    end

    assign sym_out  = sym_out_reg;
    assign sym_load = sym_load_reg;
    assign sym_is_k = sym_is_k_reg;
    assign active   = active_reg;
    assign state_o  = state_reg;

endmodule
